// File: rtl/axi4lite_pkg.sv
// Shared types and constants for the AXI4-Lite interconnect blocks.
package axi4lite_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } arb_state_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin pick: on a tie the requester other than last_grant wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_sel,
  output logic       grant_valid
);

  assign grant_valid = |req;
  assign grant_sel   = (&req) ? ~last_grant : req[1];

endmodule

// File: rtl/axi4lite_arbiter2.sv
// Two-master to one-slave AXI4-Lite arbiter: round-robin, one transaction in flight,
// granted master's channels passed through combinationally until the final handshake.
module axi4lite_arbiter2
  import axi4lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // master 0
  input  logic                  m0_arvalid,
  input  logic [ADDR_WIDTH-1:0] m0_araddr,
  output logic                  m0_arready,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [1:0]            m0_rresp,
  input  logic                  m0_rready,
  input  logic                  m0_awvalid,
  input  logic [ADDR_WIDTH-1:0] m0_awaddr,
  output logic                  m0_awready,
  input  logic                  m0_wvalid,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic [3:0]            m0_wstrb,
  output logic                  m0_wready,
  output logic                  m0_bvalid,
  output logic [1:0]            m0_bresp,
  input  logic                  m0_bready,
  // master 1
  input  logic                  m1_arvalid,
  input  logic [ADDR_WIDTH-1:0] m1_araddr,
  output logic                  m1_arready,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [1:0]            m1_rresp,
  input  logic                  m1_rready,
  input  logic                  m1_awvalid,
  input  logic [ADDR_WIDTH-1:0] m1_awaddr,
  output logic                  m1_awready,
  input  logic                  m1_wvalid,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic [3:0]            m1_wstrb,
  output logic                  m1_wready,
  output logic                  m1_bvalid,
  output logic [1:0]            m1_bresp,
  input  logic                  m1_bready,
  // slave
  output logic                  s_arvalid,
  output logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic                  s_arready,
  input  logic                  s_rvalid,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic [1:0]            s_rresp,
  output logic                  s_rready,
  output logic                  s_awvalid,
  output logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic                  s_awready,
  output logic                  s_wvalid,
  output logic [DATA_WIDTH-1:0] s_wdata,
  output logic [3:0]            s_wstrb,
  input  logic                  s_wready,
  input  logic                  s_bvalid,
  input  logic [1:0]            s_bresp,
  output logic                  s_bready
);

  arb_state_t state, state_next;
  logic       grant_sel, last_grant;
  logic       ar_done, aw_done, w_done;
  logic       arb_sel, arb_valid;

  // Master-indexed views of the flat ports so the muxes can index by grant_sel.
  logic [1:0]                 arvalid_m, rready_m, awvalid_m, wvalid_m, bready_m;
  logic [1:0][ADDR_WIDTH-1:0] araddr_m, awaddr_m;
  logic [1:0][DATA_WIDTH-1:0] wdata_m, rdata_m;
  logic [1:0][3:0]            wstrb_m;
  logic [1:0]                 arready_m, rvalid_m, awready_m, wready_m, bvalid_m;
  logic [1:0][1:0]            rresp_m, bresp_m;

  assign arvalid_m = {m1_arvalid, m0_arvalid};
  assign rready_m  = {m1_rready, m0_rready};
  assign awvalid_m = {m1_awvalid, m0_awvalid};
  assign wvalid_m  = {m1_wvalid, m0_wvalid};
  assign bready_m  = {m1_bready, m0_bready};
  assign araddr_m  = {m1_araddr, m0_araddr};
  assign awaddr_m  = {m1_awaddr, m0_awaddr};
  assign wdata_m   = {m1_wdata, m0_wdata};
  assign wstrb_m   = {m1_wstrb, m0_wstrb};

  assign m0_arready = arready_m[0];
  assign m0_rvalid  = rvalid_m[0];
  assign m0_rdata   = rdata_m[0];
  assign m0_rresp   = rresp_m[0];
  assign m0_awready = awready_m[0];
  assign m0_wready  = wready_m[0];
  assign m0_bvalid  = bvalid_m[0];
  assign m0_bresp   = bresp_m[0];
  assign m1_arready = arready_m[1];
  assign m1_rvalid  = rvalid_m[1];
  assign m1_rdata   = rdata_m[1];
  assign m1_rresp   = rresp_m[1];
  assign m1_awready = awready_m[1];
  assign m1_wready  = wready_m[1];
  assign m1_bvalid  = bvalid_m[1];
  assign m1_bresp   = bresp_m[1];

  rr_arbiter2 u_rr (
    .req         (arvalid_m | awvalid_m | wvalid_m),
    .last_grant  (last_grant),
    .grant_sel   (arb_sel),
    .grant_valid (arb_valid)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through the case infers a latch.
    state_next = state;
    s_arvalid  = 1'b0;
    s_araddr   = '0;
    s_rready   = 1'b0;
    s_awvalid  = 1'b0;
    s_awaddr   = '0;
    s_wvalid   = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_bready   = 1'b0;
    arready_m  = '0;
    rvalid_m   = '0;
    rdata_m    = '0;
    rresp_m    = {2{RESP_OKAY}};
    awready_m  = '0;
    wready_m   = '0;
    bvalid_m   = '0;
    bresp_m    = {2{RESP_OKAY}};

    case (state)
      IDLE: begin
        // Reads win within a master; its pending write is re-arbitrated afterwards.
        if (arb_valid) state_next = arvalid_m[arb_sel] ? RD : WR;
      end
      RD: begin
        s_arvalid            = arvalid_m[grant_sel] & ~ar_done;
        s_araddr             = araddr_m[grant_sel];
        s_rready             = rready_m[grant_sel];
        arready_m[grant_sel] = s_arready & ~ar_done;
        rvalid_m[grant_sel]  = s_rvalid;
        rdata_m[grant_sel]   = s_rdata;
        rresp_m[grant_sel]   = s_rresp;
        if (s_rvalid && rready_m[grant_sel]) state_next = IDLE;
      end
      WR: begin
        s_awvalid            = awvalid_m[grant_sel] & ~aw_done;
        s_awaddr             = awaddr_m[grant_sel];
        s_wvalid             = wvalid_m[grant_sel] & ~w_done;
        s_wdata              = wdata_m[grant_sel];
        s_wstrb              = wstrb_m[grant_sel];
        s_bready             = bready_m[grant_sel];
        awready_m[grant_sel] = s_awready & ~aw_done;
        wready_m[grant_sel]  = s_wready & ~w_done;
        bvalid_m[grant_sel]  = s_bvalid;
        bresp_m[grant_sel]   = s_bresp;
        if (s_bvalid && bready_m[grant_sel]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      grant_sel  <= 1'b0;
      last_grant <= 1'b1;
      ar_done    <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (arb_valid) begin
            grant_sel <= arb_sel;
            ar_done   <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
          end
        end
        RD: begin
          if (s_arvalid && s_arready) ar_done <= 1'b1;
          if (s_rvalid && s_rready) last_grant <= grant_sel;
        end
        WR: begin
          if (s_awvalid && s_awready) aw_done <= 1'b1;
          if (s_wvalid && s_wready) w_done <= 1'b1;
          if (s_bvalid && s_bready) last_grant <= grant_sel;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4lite_arbiter2.sv
// Directed bench for axi4lite_arbiter2 with a small behavioural slave and per-master driver tasks.
module tb_axi4lite_arbiter2;
  import axi4lite_pkg::*;

  localparam int SIG_AR = 0, SIG_R = 1, SIG_AW = 2, SIG_W = 3, SIG_B = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  arvalid, rready, awvalid, wvalid, bready;
  logic [31:0] araddr [2];
  logic [31:0] awaddr [2];
  logic [31:0] wdata [2];
  logic [3:0]  wstrb [2];

  logic        m0_arready, m0_rvalid, m0_awready, m0_wready, m0_bvalid;
  logic        m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [1:0]  m0_rresp, m1_rresp, m0_bresp, m1_bresp;

  logic        s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
  logic [31:0] s_araddr, s_awaddr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp, s_bresp;

  axi4lite_arbiter2 #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .m0_arvalid(arvalid[0]), .m0_araddr(araddr[0]), .m0_arready(m0_arready),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rready(rready[0]),
    .m0_awvalid(awvalid[0]), .m0_awaddr(awaddr[0]), .m0_awready(m0_awready),
    .m0_wvalid(wvalid[0]), .m0_wdata(wdata[0]), .m0_wstrb(wstrb[0]), .m0_wready(m0_wready),
    .m0_bvalid(m0_bvalid), .m0_bresp(m0_bresp), .m0_bready(bready[0]),
    .m1_arvalid(arvalid[1]), .m1_araddr(araddr[1]), .m1_arready(m1_arready),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rready(rready[1]),
    .m1_awvalid(awvalid[1]), .m1_awaddr(awaddr[1]), .m1_awready(m1_awready),
    .m1_wvalid(wvalid[1]), .m1_wdata(wdata[1]), .m1_wstrb(wstrb[1]), .m1_wready(m1_wready),
    .m1_bvalid(m1_bvalid), .m1_bresp(m1_bresp), .m1_bready(bready[1]),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave behaviour: read data is a fixed function of the address; 0xE... addresses answer SLVERR.
  function automatic logic [31:0] slv_rdata(input logic [31:0] a);
    if (a == 32'ha000_0048) return 32'h0000_1234;
    return a ^ 32'h5a5a_5a5a;
  endfunction

  function automatic logic [1:0] slv_resp(input logic [31:0] a);
    return (a[31:28] == 4'he) ? 2'b10 : 2'b00;
  endfunction

  int          rd_lat = 0;
  int          rd_cnt = -1;
  bit          ar_fire, r_fire, aw_fire, w_fire, b_fire, got_aw, got_w;
  logic [31:0] rd_addr, wr_addr;

  // Slave drives at negedge+1 and latches which handshakes will occur at negedge+2.
  initial begin
    s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0;
    rd_addr = 0; wr_addr = 0; got_aw = 0; got_w = 0;
    ar_fire = 0; r_fire = 0; aw_fire = 0; w_fire = 0; b_fire = 0;
    forever begin
      @(negedge clk); #1;
      if (!rst) begin
        s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0;
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0;
        rd_cnt = -1; got_aw = 0; got_w = 0;
      end else begin
        if (ar_fire) begin s_arready = 0; rd_cnt = rd_lat; end
        if (r_fire)  begin s_rvalid = 0; s_rdata = 0; s_rresp = 0; end
        if (aw_fire) begin s_awready = 0; got_aw = 1; end
        if (w_fire)  begin s_wready = 0; got_w = 1; end
        if (b_fire)  begin s_bvalid = 0; s_bresp = 0; end
        if (rd_cnt == 0) begin
          s_rvalid = 1; s_rdata = slv_rdata(rd_addr); s_rresp = slv_resp(rd_addr); rd_cnt = -1;
        end else if (rd_cnt > 0) rd_cnt--;
        if (s_arvalid && !s_arready && !s_rvalid && rd_cnt < 0) s_arready = 1;
        if (s_awvalid && !s_awready && !got_aw) s_awready = 1;
        if (s_wvalid && !s_wready && !got_w) s_wready = 1;
        if (got_aw && got_w && !s_bvalid) begin
          s_bvalid = 1; s_bresp = slv_resp(wr_addr); got_aw = 0; got_w = 0;
        end
      end
      #1;
      ar_fire = s_arvalid & s_arready;
      r_fire  = s_rvalid & s_rready;
      aw_fire = s_awvalid & s_awready;
      w_fire  = s_wvalid & s_wready;
      b_fire  = s_bvalid & s_bready;
      if (ar_fire) rd_addr = s_araddr;
      if (aw_fire) wr_addr = s_awaddr;
    end
  end

  // Edge monitor: handshake counts, logs and timing marks.
  int          cyc = 0, ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  int          m1_act = 0, bv_diff = 0, arv_rise_cyc = 0, aw_cyc = 0;
  logic        arv_prev = 0;
  logic [31:0] ar_log [64];
  int          r_cyc_log [64];
  logic [31:0] aw_addr_seen = 0, w_data_seen = 0;
  logic [3:0]  w_strb_seen = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (s_arvalid && s_arready) begin ar_log[ar_cnt % 64] <= s_araddr; ar_cnt <= ar_cnt + 1; end
    if (s_rvalid && s_rready) begin r_cyc_log[r_cnt % 64] <= cyc; r_cnt <= r_cnt + 1; end
    if (s_awvalid && s_awready) begin aw_cnt <= aw_cnt + 1; aw_cyc <= cyc; aw_addr_seen <= s_awaddr; end
    if (s_wvalid && s_wready) begin w_cnt <= w_cnt + 1; w_data_seen <= s_wdata; w_strb_seen <= s_wstrb; end
    if (s_bvalid && s_bready) b_cnt <= b_cnt + 1;
    arv_prev <= s_arvalid;
    if (s_arvalid && !arv_prev) arv_rise_cyc <= cyc;
    if (m1_arready || m1_rvalid || m1_awready || m1_wready || m1_bvalid) m1_act <= m1_act + 1;
    if (s_bvalid !== m1_bvalid) bv_diff <= bv_diff + 1;
  end

  function automatic logic sig_of(input int m, input int which);
    case (which)
      SIG_AR:  return m != 0 ? m1_arready : m0_arready;
      SIG_R:   return m != 0 ? m1_rvalid  : m0_rvalid;
      SIG_AW:  return m != 0 ? m1_awready : m0_awready;
      SIG_W:   return m != 0 ? m1_wready  : m0_wready;
      default: return m != 0 ? m1_bvalid  : m0_bvalid;
    endcase
  endfunction

  function automatic logic [14:0] ctrl_outs();
    return {s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready,
            m0_arready, m0_rvalid, m0_awready, m0_wready, m0_bvalid,
            m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid};
  endfunction

  function automatic logic data_any();
    return |{s_araddr, s_awaddr, s_wdata, s_wstrb, m0_rdata, m0_rresp, m0_bresp,
             m1_rdata, m1_rresp, m1_bresp};
  endfunction

  // Called at a negedge; samples at +3 and returns at the negedge after the handshake edge.
  task automatic wait_sig(input int m, input int which, input string tag,
                          output logic [31:0] data, output logic [1:0] resp);
    bit hit;
    hit = 0; data = 0; resp = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      #3;
      if (sig_of(m, which)) begin
        hit  = 1;
        data = (m != 0) ? m1_rdata : m0_rdata;
        resp = (which == SIG_B) ? ((m != 0) ? m1_bresp : m0_bresp)
                                : ((m != 0) ? m1_rresp : m0_rresp);
      end
      @(negedge clk);
    end
    check({tag, "_handshake"}, hit, 1);
  endtask

  task automatic do_read(input int m, input logic [31:0] addr,
                         output logic [31:0] data, output logic [1:0] resp);
    logic [31:0] d;
    logic [1:0]  r;
    arvalid[m] = 1; araddr[m] = addr;
    wait_sig(m, SIG_AR, "ar", d, r);
    arvalid[m] = 0; araddr[m] = 0;
    wait_sig(m, SIG_R, "r", data, resp);
  endtask

  task automatic do_write(input int m, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int w_delay, output logic [1:0] resp);
    logic [31:0] d;
    fork
      begin
        logic [31:0] da; logic [1:0] ra;
        awvalid[m] = 1; awaddr[m] = addr;
        wait_sig(m, SIG_AW, "aw", da, ra);
        awvalid[m] = 0; awaddr[m] = 0;
      end
      begin
        logic [31:0] dw; logic [1:0] rw;
        repeat (w_delay) @(negedge clk);
        wvalid[m] = 1; wdata[m] = data; wstrb[m] = strb;
        wait_sig(m, SIG_W, "w", dw, rw);
        wvalid[m] = 0; wdata[m] = 0; wstrb[m] = 0;
      end
    join
    wait_sig(m, SIG_B, "b", d, resp);
  endtask

  logic [31:0] d0, d1, fd0, fd1;
  logic [1:0]  r0, r1, fr0, fr1;
  int          base_ar, base_r, base_aw, base_w, base_b, snap_act, snap_bv;

  initial begin
    arvalid = 0; awvalid = 0; wvalid = 0; rready = 2'b11; bready = 2'b11;
    for (int i = 0; i < 2; i++) begin araddr[i] = 0; awaddr[i] = 0; wdata[i] = 0; wstrb[i] = 0; end

    // Reset state.
    repeat (3) @(negedge clk);
    #3;
    check("reset_ctrl", ctrl_outs(), 0);
    check("reset_data", data_any(), 0);

    // Tie in the first cycle after reset: m0 first, m1 after one idle cycle.
    @(negedge clk);
    rst = 1; rd_lat = 2;
    base_ar = ar_cnt; base_r = r_cnt;
    fork
      do_read(0, 32'ha000_0100, d0, r0);
      do_read(1, 32'ha000_0200, d1, r1);
    join
    check("tie_first_addr", ar_log[base_ar % 64], 32'ha000_0100);
    check("tie_second_addr", ar_log[(base_ar + 1) % 64], 32'ha000_0200);
    check("tie_m0_data", d0, 32'hfa5a_5b5a);
    check("tie_m1_data", d1, 32'hfa5a_585a);
    check("tie_gap", arv_rise_cyc - r_cyc_log[base_r % 64], 2);

    // Fairness: four back-to-back reads from each master alternate 0,1,0,1,...
    base_ar = ar_cnt; rd_lat = 1;
    fork
      for (int i = 0; i < 4; i++) begin
        do_read(0, 32'h1000_0000 + 32'(i * 4), fd0, fr0);
        check("fair_m0_data", fd0, (32'h1000_0000 + 32'(i * 4)) ^ 32'h5a5a_5a5a);
      end
      for (int i = 0; i < 4; i++) begin
        do_read(1, 32'h2000_0000 + 32'(i * 4), fd1, fr1);
        check("fair_m1_data", fd1, (32'h2000_0000 + 32'(i * 4)) ^ 32'h5a5a_5a5a);
      end
    join
    for (int k = 0; k < 8; k++) begin
      logic [31:0] a;
      a = ar_log[(base_ar + k) % 64];
      check("fair_order", a[31:28], (k % 2 != 0) ? 4'h2 : 4'h1);
    end

    // Single read with random slave latency; m1 must stay silent.
    rd_lat = $urandom_range(0, 7);
    snap_act = m1_act; base_ar = ar_cnt; base_r = r_cnt;
    do_read(0, 32'ha000_0048, d0, r0);
    check("single_rdata", d0, 32'h0000_1234);
    check("single_rresp", r0, 2'b00);
    check("single_m1_quiet", m1_act - snap_act, 0);
    check("single_ar_count", ar_cnt - base_ar, 1);
    check("single_r_count", r_cnt - base_r, 1);

    // Error response passes through unmodified.
    rd_lat = 0;
    do_read(1, 32'he000_0010, d1, r1);
    check("slverr_rdata", d1, 32'hba5a_5a4a);
    check("slverr_rresp", r1, 2'b10);

    // Decoupled write: W arrives three cycles after AW.
    base_aw = aw_cnt; base_w = w_cnt; base_b = b_cnt; snap_bv = bv_diff;
    do_write(1, 32'ha000_004c, 32'h0000_0005, 4'hf, 3, r1);
    check("dec_aw_count", aw_cnt - base_aw, 1);
    check("dec_w_count", w_cnt - base_w, 1);
    check("dec_b_count", b_cnt - base_b, 1);
    check("dec_awaddr", aw_addr_seen, 32'ha000_004c);
    check("dec_wdata", w_data_seen, 32'h0000_0005);
    check("dec_wstrb", w_strb_seen, 4'hf);
    check("dec_bresp", r1, 2'b00);
    check("dec_bvalid_follow", bv_diff - snap_bv, 0);

    // Mixed: read and write from m1 together; read is served first.
    base_ar = ar_cnt; base_r = r_cnt; base_aw = aw_cnt; base_w = w_cnt; base_b = b_cnt;
    rd_lat = 3;
    fork
      do_read(1, 32'ha000_0060, d1, r1);
      do_write(1, 32'he000_0064, 32'hcafe_f00d, 4'h3, 0, r0);
    join
    check("mix_ar_count", ar_cnt - base_ar, 1);
    check("mix_r_count", r_cnt - base_r, 1);
    check("mix_aw_count", aw_cnt - base_aw, 1);
    check("mix_w_count", w_cnt - base_w, 1);
    check("mix_b_count", b_cnt - base_b, 1);
    check("mix_read_first", aw_cyc > r_cyc_log[base_r % 64], 1);
    check("mix_rdata", d1, 32'hfa5a_5a3a);
    check("mix_wdata", w_data_seen, 32'hcafe_f00d);
    check("mix_wstrb", w_strb_seen, 4'h3);
    check("mix_bresp", r0, 2'b10);

    // Reset while the slave stalls a read, then a clean read afterwards.
    rd_lat = 30;
    arvalid[0] = 1; araddr[0] = 32'ha000_0070;
    wait_sig(0, SIG_AR, "stall_ar", d0, r0);
    arvalid[0] = 0; araddr[0] = 0;
    repeat (2) @(negedge clk);
    #3;
    check("stall_in_rd", s_rready, 1);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    #3;
    check("midrst_ctrl", ctrl_outs(), 0);
    check("midrst_data", data_any(), 0);
    @(negedge clk);
    rst = 1; rd_lat = 1;
    do_read(0, 32'ha000_0048, d0, r0);
    check("post_rst_rdata", d0, 32'h0000_1234);
    check("post_rst_rresp", r0, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
